// File: rtl/apb_regfile_slave.sv
// APB completer for one Pselx slot: 16-word register file with programmable wait states,
// error response, successful-write counter (reg 14), fixed ID (reg 15) and a sticky protocol flag.
module apb_regfile_slave #(
    parameter int          SEL_INDEX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr,
    output logic        proto_err
);

    // Handshake: a transfer is a setup cycle (psel=1, Penable=0) followed by access
    // cycles (psel=1, Penable=1); it completes on the access cycle where Pready=1.
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_addr;
    logic        r_write;
    logic [31:0] r_wdata;
    logic [1:0]  r_wcnt;
    logic [31:0] r_regs [0:13];
    logic [31:0] r_wr_cnt;
    logic        r_proto_err;

    logic        w_psel;
    logic        w_unused_sel;
    logic [3:0]  w_idx;
    logic        w_addr_ok;
    logic        w_ro_target;
    logic        w_err;
    logic        w_setup;
    logic        w_access;
    logic        w_complete;
    logic        w_commit;
    logic        w_proto_set;
    logic [31:0] w_rd_mux;

    assign w_psel       = Pselx[SEL_INDEX];
    assign w_unused_sel = ^Pselx;

    // All decode works on the captured address so a wandering live bus cannot corrupt the transfer.
    assign w_idx       = r_addr[5:2];
    assign w_addr_ok   = (r_addr[31:6] == BASE_ADDR[31:6]) && (r_addr[1:0] == 2'b00);
    assign w_ro_target = (w_idx == 4'd14) || (w_idx == 4'd15);
    assign w_err       = !w_addr_ok || (r_write && w_ro_target);

    assign w_setup    = (r_state == ST_IDLE) && w_psel && !Penable;
    assign w_access   = (r_state == ST_ACCESS) && w_psel && Penable;
    assign w_complete = w_access && (r_wcnt == 2'd0);
    assign w_commit   = w_complete && r_write && !w_err;

    assign w_proto_set = ((r_state == ST_IDLE) && w_psel && Penable)
                       || ((r_state == ST_ACCESS) && w_psel && !Penable)
                       || (w_access && ((Paddr != r_addr) || (Pwrite != r_write)));

    // State register
    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_psel && !Penable) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!w_psel || !Penable || (r_wcnt == 2'd0)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_idx)
            4'd14:   w_rd_mux = r_wr_cnt;
            4'd15:   w_rd_mux = ID_VALUE;
            default: w_rd_mux = r_regs[w_idx];
        endcase
    end

    // Output logic
    always_comb begin
        Pready  = 1'b0;
        Pslverr = 1'b0;
        Prdata  = 32'h0;
        if (w_complete) begin
            Pready  = 1'b1;
            Pslverr = w_err;
            if (!r_write && w_addr_ok) begin
                Prdata = w_rd_mux;
            end
        end
    end

    assign proto_err = r_proto_err;

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            r_addr      <= 32'h0;
            r_write     <= 1'b0;
            r_wdata     <= 32'h0;
            r_wcnt      <= 2'd0;
            r_wr_cnt    <= 32'h0;
            r_proto_err <= 1'b0;
            for (int i = 0; i < 14; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else begin
            if (w_setup) begin
                r_addr  <= Paddr;
                r_write <= Pwrite;
                r_wdata <= Pwdata;
                r_wcnt  <= 2'(WAIT_STATES);
            end
            if (w_access && (r_wcnt != 2'd0)) begin
                r_wcnt <= r_wcnt - 2'd1;
            end
            if (w_commit) begin
                r_regs[w_idx] <= r_wdata;
                r_wr_cnt      <= r_wr_cnt + 32'd1;
            end
            if (w_proto_set) begin
                r_proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Directed bench: two instances on the same APB bus, slot 0 with no wait states
// and slot 1 with two wait states.
module tb_apb_regfile_slave;

    logic        Hclk = 1'b0;
    logic        Hreset;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;

    logic [31:0] rd0, rd1;
    logic        rdy0, rdy1, err0, err1, pe0, pe1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Hclk = ~Hclk;

    apb_regfile_slave #(.SEL_INDEX(0), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ID_VALUE(32'hA5B0_0001)) dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd0), .Pready(rdy0), .Pslverr(err0), .proto_err(pe0)
    );

    apb_regfile_slave #(.SEL_INDEX(1), .BASE_ADDR(32'h0), .WAIT_STATES(2), .ID_VALUE(32'hA5B0_0001)) dut2 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(rd1), .Pready(rdy1), .Pslverr(err1), .proto_err(pe1)
    );

    // Setup then access phases; returns right after sampling the completing cycle.
    task automatic apb_xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit skip_edge, output logic [31:0] rdata, output logic slverr, output int nwait);
        bit done;
        if (!skip_edge) @(negedge Hclk);
        Pselx   = (d == 0) ? 3'b001 : 3'b010;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = wdata;
        @(negedge Hclk);
        Penable = 1'b1;
        nwait   = 0;
        done    = 1'b0;
        rdata   = 32'hx;
        slverr  = 1'bx;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if (((d == 0) ? rdy0 : rdy1) === 1'b1) begin
                done   = 1'b1;
                rdata  = (d == 0) ? rd0 : rd1;
                slverr = (d == 0) ? err0 : err1;
            end else begin
                nwait++;
                @(negedge Hclk);
            end
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL xfer_timeout: addr %h got no Pready, required Pready=1 within 8 cycles", addr);
        end
    endtask

    task automatic bus_idle();
        @(negedge Hclk);
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    task automatic test_reset();
        Hreset = 1'b1; Pselx = 3'b000; Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0; Pwdata = 32'h0;
        repeat (2) @(negedge Hclk);
        #1;
        n_cmp++; if (rdy0 !== 1'b0 || rdy1 !== 1'b0) begin n_bad++; $display("FAIL reset_pready: got %b%b want 00", rdy0, rdy1); end
        n_cmp++; if (err0 !== 1'b0 || err1 !== 1'b0) begin n_bad++; $display("FAIL reset_pslverr: got %b%b want 00", err0, err1); end
        n_cmp++; if (rd0 !== 32'h0 || rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_prdata: got %h %h want 0", rd0, rd1); end
        n_cmp++; if (pe0 !== 1'b0 || pe1 !== 1'b0) begin n_bad++; $display("FAIL reset_proto: got %b%b want 00", pe0, pe1); end
        @(negedge Hclk);
        Hreset = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic se; int nw;
        logic [31:0] bad_addr [3];
        bad_addr[0] = 32'h38; bad_addr[1] = 32'h0A; bad_addr[2] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            apb_xfer(0, 1'b1, bad_addr[i], 32'h1234_5678, 1'b0, rd, se, nw);
            n_cmp++; if (se !== 1'b1) begin n_bad++; $display("FAIL err_write_slverr: addr %h got %b want 1", bad_addr[i], se); end
        end
        apb_xfer(0, 1'b0, 32'h40, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (se !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_read: slverr %b data %h want 1 00000000", se, rd); end
        apb_xfer(0, 1'b0, 32'h38, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h0 || se !== 1'b0) begin n_bad++; $display("FAIL err_cnt_unchanged: got %h/%b want 00000000/0", rd, se); end
        bus_idle();
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic se; int nw;
        apb_xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0, rd, se, nw);
        n_cmp++; if (se !== 1'b0 || nw != 0) begin n_bad++; $display("FAIL wr_resp: slverr %b waits %0d want 0 0", se, nw); end
        bus_idle();
        #1;
        n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL pready_one_cycle: got %b want 0", rdy0); end
        apb_xfer(0, 1'b0, 32'h08, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'hDEAD_BEEF || se !== 1'b0) begin n_bad++; $display("FAIL rd_data: got %h/%b want deadbeef/0", rd, se); end
        apb_xfer(0, 1'b0, 32'h38, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h1) begin n_bad++; $display("FAIL wr_count: got %h want 00000001", rd); end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic se; int nw;
        apb_xfer(0, 1'b1, 32'h00, 32'h1111_1111, 1'b0, rd, se, nw);
        apb_xfer(0, 1'b1, 32'h04, 32'h2222_2222, 1'b0, rd, se, nw);
        apb_xfer(0, 1'b0, 32'h00, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h1111_1111) begin n_bad++; $display("FAIL b2b_rd0: got %h want 11111111", rd); end
        apb_xfer(0, 1'b0, 32'h04, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h2222_2222) begin n_bad++; $display("FAIL b2b_rd1: got %h want 22222222", rd); end
        apb_xfer(0, 1'b0, 32'h38, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h3) begin n_bad++; $display("FAIL b2b_count: got %h want 00000003", rd); end
        bus_idle();
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic se; int nw;
        apb_xfer(1, 1'b0, 32'h3C, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (nw != 2) begin n_bad++; $display("FAIL ws_count: got %0d wait cycles want 2", nw); end
        n_cmp++; if (rd !== 32'hA5B0_0001 || se !== 1'b0) begin n_bad++; $display("FAIL ws_id: got %h/%b want a5b00001/0", rd, se); end
        bus_idle();
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic se; int nw;
        @(negedge Hclk);
        force dut0.r_wr_cnt = 32'hFFFF_FFFE;
        @(negedge Hclk);
        release dut0.r_wr_cnt;
        for (int i = 0; i < 4; i++) begin
            apb_xfer(0, 1'b1, 32'h10 + 32'(i * 4), 32'hC0DE_0000 + 32'(i), 1'b0, rd, se, nw);
        end
        apb_xfer(0, 1'b0, 32'h38, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h0000_0002) begin n_bad++; $display("FAIL wrap_count: got %h want 00000002", rd); end
        apb_xfer(0, 1'b0, 32'h1C, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'hC0DE_0003) begin n_bad++; $display("FAIL wrap_reg7: got %h want c0de0003", rd); end
        bus_idle();
    endtask

    task automatic test_proto_no_setup();
        @(negedge Hclk);
        #1;
        n_cmp++; if (pe0 !== 1'b0) begin n_bad++; $display("FAIL proto_pre: got %b want 0", pe0); end
        Pselx = 3'b001; Penable = 1'b1; Pwrite = 1'b0; Paddr = 32'h0;
        #1;
        n_cmp++; if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL proto_no_ready: got %b want 0", rdy0); end
        @(negedge Hclk);
        #1;
        n_cmp++; if (pe0 !== 1'b1 || rdy0 !== 1'b0) begin n_bad++; $display("FAIL proto_flag: proto %b ready %b want 1 0", pe0, rdy0); end
        Pselx = 3'b000; Penable = 1'b0;
        @(negedge Hclk);
        #1;
        n_cmp++; if (pe0 !== 1'b1) begin n_bad++; $display("FAIL proto_sticky: got %b want 1", pe0); end
    endtask

    task automatic test_psel_abort();
        logic [31:0] rd; logic se; int nw;
        apb_xfer(1, 1'b1, 32'h0C, 32'hAAAA_0000, 1'b0, rd, se, nw);
        bus_idle();
        @(negedge Hclk);
        Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h0C; Pwdata = 32'h5555_5555;
        @(negedge Hclk);
        Penable = 1'b1;
        #1;
        n_cmp++; if (rdy1 !== 1'b0) begin n_bad++; $display("FAIL abort_wait: got %b want 0", rdy1); end
        @(negedge Hclk);
        Pselx = 3'b000; Penable = 1'b0;
        apb_xfer(1, 1'b0, 32'h0C, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'hAAAA_0000) begin n_bad++; $display("FAIL abort_no_write: got %h want aaaa0000", rd); end
        n_cmp++; if (pe1 !== 1'b0) begin n_bad++; $display("FAIL abort_proto: got %b want 0", pe1); end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic se; int nw;
        @(negedge Hclk);
        Pselx = 3'b010; Penable = 1'b0; Pwrite = 1'b1; Paddr = 32'h14; Pwdata = 32'hCAFE_F00D;
        @(negedge Hclk);
        Penable = 1'b1;
        #1;
        Hreset = 1'b1;
        @(negedge Hclk);
        #1;
        n_cmp++; if (rdy1 !== 1'b0 || err1 !== 1'b0 || rd1 !== 32'h0) begin n_bad++; $display("FAIL rst_mid_outputs: %b %b %h want 0 0 00000000", rdy1, err1, rd1); end
        n_cmp++; if (pe0 !== 1'b0) begin n_bad++; $display("FAIL rst_mid_proto_clear: got %b want 0", pe0); end
        Hreset = 1'b0;
        apb_xfer(1, 1'b0, 32'h14, 32'h0, 1'b1, rd, se, nw);
        n_cmp++; if (rd !== 32'h0 || nw != 2) begin n_bad++; $display("FAIL rst_mid_reg: got %h waits %0d want 00000000 2", rd, nw); end
        apb_xfer(0, 1'b0, 32'h38, 32'h0, 1'b0, rd, se, nw);
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mid_count: got %h want 00000000", rd); end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_errors();
        test_write_read();
        test_back_to_back();
        test_wait_states();
        test_wrap();
        test_proto_no_setup();
        test_psel_abort();
        test_reset_mid();
        repeat (2) @(negedge Hclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
